// File: rtl/onehot_codec_if.sv
// Handshake and data bundle for the registered one-hot decoder/encoder.
// Master drives transactions; slave is the codec.
interface onehot_codec_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
) ();
  localparam int V = 1 << N;

  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     code_in;
  logic [V-1:0]     vec_in;
  logic             out_valid;
  logic             out_ready;
  logic [V-1:0]     vec_out;
  logic [N-1:0]     code_out;
  logic             hit;
  logic             multi;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  modport master (
    output mode, in_valid, code_in, vec_in,
    output out_ready, err_clr,
    input  in_ready, out_valid, vec_out,
    input  code_out, hit, multi, err_cnt
  );

  modport slave (
    input  mode, in_valid, code_in, vec_in,
    input  out_ready, err_clr,
    output in_ready, out_valid, vec_out,
    output code_out, hit, multi, err_cnt
  );
endinterface

// File: rtl/onehot_codec.sv
// Registered N-to-2^N decoder and 2^N-to-N lowest-index priority encoder
// behind a one-entry valid/ready output register, with a fault counter.
module onehot_codec #(
  parameter int N     = 2,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  onehot_codec_if.slave  bus
);
  localparam int V = 1 << N;
  localparam logic [V-1:0] L_ONE = V'(1);

  logic             r_out_valid;
  logic [V-1:0]     r_vec;
  logic [N-1:0]     r_code;
  logic             r_hit;
  logic             r_multi;
  logic [CNT_W-1:0] r_err;

  logic             w_in_ready;
  logic             w_acc;
  logic [V-1:0]     w_dec;
  logic [V-1:0]     w_iso;
  logic [N-1:0]     w_enc_code;
  logic             w_enc_hit;
  logic             w_enc_multi;
  logic             w_fault;
  logic             w_sat;

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_acc      = bus.in_valid & w_in_ready;

  always_comb begin
    w_dec = '0;
    w_dec[bus.code_in] = 1'b1;
  end

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_enc_code = '0;
    for (int i = V - 1; i >= 0; i--) begin
      if (bus.vec_in[i]) w_enc_code = N'(i);
    end
  end

  assign w_iso       = bus.vec_in & (~bus.vec_in + L_ONE);
  assign w_enc_hit   = |bus.vec_in;
  assign w_enc_multi = |(bus.vec_in & (bus.vec_in - L_ONE));
  assign w_fault     = w_enc_multi | ~w_enc_hit;
  assign w_sat       = &r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_vec       <= '0;
      r_code      <= '0;
      r_hit       <= 1'b0;
      r_multi     <= 1'b0;
      r_err       <= '0;
    end else begin
      if (w_acc) begin
        r_out_valid <= 1'b1;
        if (bus.mode) begin
          r_vec   <= w_iso;
          r_code  <= w_enc_code;
          r_hit   <= w_enc_hit;
          r_multi <= w_enc_multi;
        end else begin
          r_vec   <= w_dec;
          r_code  <= bus.code_in;
          r_hit   <= 1'b1;
          r_multi <= 1'b0;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (bus.err_clr) begin
        r_err <= '0;
      end else if (w_acc & bus.mode & w_fault & ~w_sat) begin
        r_err <= r_err + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.vec_out   = r_vec;
  assign bus.code_out  = r_code;
  assign bus.hit       = r_hit;
  assign bus.multi     = r_multi;
  assign bus.err_cnt   = r_err;
endmodule

// File: tb/tb_onehot_codec.sv
// Directed bench for onehot_codec: N=2 (CNT_W 8 and 2) and N=4 instances.
module tb_onehot_codec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  onehot_codec_if #(.N(2), .CNT_W(8)) bA ();
  onehot_codec_if #(.N(2), .CNT_W(2)) bB ();
  onehot_codec_if #(.N(4), .CNT_W(8)) bC ();

  onehot_codec #(.N(2), .CNT_W(8)) uA (.clk(clk), .rst(rst), .bus(bA));
  onehot_codec #(.N(2), .CNT_W(2)) uB (.clk(clk), .rst(rst), .bus(bB));
  onehot_codec #(.N(4), .CNT_W(8)) uC (.clk(clk), .rst(rst), .bus(bC));

  typedef struct {
    logic       mode;
    logic [1:0] code;
    logic [3:0] vec;
    logic [3:0] e_vec;
    logic [1:0] e_code;
    logic       e_hit;
    logic       e_multi;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'd0, 4'h0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 4'h0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 2'd2, 4'h0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'd3, 4'h0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 2'd3, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    bA.mode = 0; bA.in_valid = 0; bA.code_in = 0; bA.vec_in = 0;
    bA.out_ready = 1; bA.err_clr = 0;
    bB.mode = 0; bB.in_valid = 0; bB.code_in = 0; bB.vec_in = 0;
    bB.out_ready = 1; bB.err_clr = 0;
    bC.mode = 0; bC.in_valid = 0; bC.code_in = 0; bC.vec_in = 0;
    bC.out_ready = 1; bC.err_clr = 0;

    #12 rst = 1'b0;
    step();
    chk("rst_valid", 32'(bA.out_valid), 0);
    chk("rst_vec", 32'(bA.vec_out), 0);
    chk("rst_err", 32'(bA.err_cnt), 0);
    chk("rst_ready", 32'(bA.in_ready), 1);

    // Back-to-back table, one accept per cycle
    for (int i = 0; i < 7; i++) begin
      bA.mode = tbl[i].mode;
      bA.code_in = tbl[i].code;
      bA.vec_in = tbl[i].vec;
      bA.in_valid = 1;
      chk($sformatf("t%0d_ready", i), 32'(bA.in_ready), 1);
      step();
      chk($sformatf("t%0d_valid", i), 32'(bA.out_valid), 1);
      chk($sformatf("t%0d_vec", i), 32'(bA.vec_out), 32'(tbl[i].e_vec));
      chk($sformatf("t%0d_code", i), 32'(bA.code_out), 32'(tbl[i].e_code));
      chk($sformatf("t%0d_hit", i), 32'(bA.hit), 32'(tbl[i].e_hit));
      chk($sformatf("t%0d_multi", i), 32'(bA.multi), 32'(tbl[i].e_multi));
    end
    bA.in_valid = 0;
    chk("enc_err", 32'(bA.err_cnt), 2);
    step();
    chk("drain_valid", 32'(bA.out_valid), 0);
    chk("drain_hold_code", 32'(bA.code_out), 0);

    // Backpressure
    bA.mode = 0; bA.code_in = 3; bA.in_valid = 1;
    step();
    chk("bp_first", 32'(bA.vec_out), 32'h8);
    bA.code_in = 1; bA.out_ready = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_ready", k), 32'(bA.in_ready), 0);
      step();
      chk($sformatf("bp%0d_vec", k), 32'(bA.vec_out), 32'h8);
      chk($sformatf("bp%0d_valid", k), 32'(bA.out_valid), 1);
    end
    bA.out_ready = 1;
    step();
    bA.in_valid = 0;
    chk("bp_new_vec", 32'(bA.vec_out), 32'h2);
    chk("bp_new_valid", 32'(bA.out_valid), 1);
    step();
    chk("bp_done", 32'(bA.out_valid), 0);

    bA.err_clr = 1;
    step();
    bA.err_clr = 0;
    chk("clr_err", 32'(bA.err_cnt), 0);

    // Saturation on the CNT_W=2 instance
    bB.mode = 1; bB.vec_in = 4'hF; bB.in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat%0d", k), 32'(bB.err_cnt), (k < 3) ? k + 1 : 3);
    end
    chk("sat_code", 32'(bB.code_out), 0);
    chk("sat_vec", 32'(bB.vec_out), 1);
    chk("sat_multi", 32'(bB.multi), 1);
    bB.err_clr = 1;
    step();
    bB.err_clr = 0; bB.in_valid = 0;
    chk("sat_clr", 32'(bB.err_cnt), 0);

    // Async reset with a result pending
    bA.mode = 1; bA.vec_in = 0; bA.in_valid = 1;
    step();
    bA.mode = 0; bA.code_in = 2; bA.out_ready = 0;
    step();
    bA.in_valid = 0;
    chk("pre_rst_valid", 32'(bA.out_valid), 1);
    chk("pre_rst_err", 32'(bA.err_cnt), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bA.out_valid), 0);
    chk("arst_vec", 32'(bA.vec_out), 0);
    chk("arst_code", 32'(bA.code_out), 0);
    chk("arst_hit", 32'(bA.hit), 0);
    chk("arst_multi", 32'(bA.multi), 0);
    chk("arst_err", 32'(bA.err_cnt), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(bA.in_ready), 1);
    bA.code_in = 1; bA.in_valid = 1;
    step();
    bA.in_valid = 0;
    chk("post_rst_valid", 32'(bA.out_valid), 1);
    chk("post_rst_vec", 32'(bA.vec_out), 32'h2);
    chk("post_rst_code", 32'(bA.code_out), 1);

    // N=4 encode
    bC.mode = 1; bC.vec_in = 16'h8000; bC.in_valid = 1;
    step();
    chk("n4a_code", 32'(bC.code_out), 15);
    chk("n4a_vec", 32'(bC.vec_out), 32'h8000);
    chk("n4a_multi", 32'(bC.multi), 0);
    chk("n4a_hit", 32'(bC.hit), 1);
    bC.vec_in = 16'h8001;
    step();
    bC.in_valid = 0;
    chk("n4b_code", 32'(bC.code_out), 0);
    chk("n4b_vec", 32'(bC.vec_out), 32'h0001);
    chk("n4b_multi", 32'(bC.multi), 1);
    chk("n4b_err", 32'(bC.err_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
